spi_cmd_ctrl: RTL

Sequencer and command decoder for the spi_mod shift-register datapath in the actuator controller.
- Drives spi_mod's enable_sn and data_valid_n, and supplies its data_in.
- Tracks SPI frames itself by synchronising ss_n and sclk.
- Decodes each completed 32-bit frame into a register read or write against a bank of actuator configuration registers.
- Preloads the response word into spi_mod, so it is shifted out on the next frame.

---
 rtl/spi_cmd_ctrl_pkg.sv | 29 ++
 rtl/spi_edge_sync.sv | 36 +++
 rtl/spi_cmd_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ctrl_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command controller.
//   - state_e        : sequencer states
//   - CMD_*          : bit positions of the fields in a 32-bit command word
//   - RESP_*         : response words preloaded into spi_mod on bad frames
//   - sat_inc8()     : saturating 8-bit increment used by the error counter
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FRAME    = 3'd1,
        SETTLE_W = 3'd2,
        DECODE   = 3'd3,
        LOAD     = 3'd4
    } state_e;

    localparam int CMD_W_BIT   = 31;
    localparam int CMD_ADDR_HI = 30;
    localparam int CMD_ADDR_LO = 24;
    localparam int CMD_DATA_HI = 23;
    localparam int CMD_DATA_LO = 0;

    localparam logic [31:0] RESP_FRAME_ERR = 32'hFFFF_FFFF;
    localparam logic [31:0] RESP_ADDR_ERR  = 32'hFF00_0000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 3-flop synchroniser with rise/fall detection.
// Matches the synchroniser inside spi_mod so both blocks see edges on the
// same cycle.
//   clock, reset : system clock, synchronous active-high reset
//   din_i        : raw asynchronous input
//   level_o      : synchronised level (sync[1])
//   rise_o       : one-cycle pulse, sync[2:1] == 01
//   fall_o       : one-cycle pulse, sync[2:1] == 10
module spi_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // sync_q[0] is the newest sample, sync_q[2] the oldest.
    assign sync_d = {sync_q[1:0], din_i};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = (sync_q[2:1] == 2'b01);
    assign fall_o  = (sync_q[2:1] == 2'b10);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: sequencer and command decoder for the spi_mod datapath.
// Tracks frames from synchronised ss_n/sclk, decodes each finished frame
// into a register read or write, and preloads the response into spi_mod.
//   clock, reset        : system clock, synchronous active-high reset
//   ctrl_enable         : 1 = command interface enabled
//   ss_n, sclk          : raw SPI select / clock (also wired to spi_mod)
//   spi_data_out        : word received by spi_mod
//   spi_enable_n        : spi_mod enable, registered ~ctrl_enable
//   spi_data_valid_n    : active-low one-cycle load strobe into spi_mod
//   spi_data_in         : response word to load
//   reg_bus             : flattened register bank, reg i at [i*REG_W +: REG_W]
//   wr_strobe, wr_addr  : one-cycle pulse and address of each register write
//   frame_err_cnt       : saturating count of bad frames
// Load handshake: spi_data_in is valid whenever spi_data_valid_n is low;
// spi_mod takes it on that single cycle, there is no back-pressure.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 24,
    parameter int SETTLE   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ctrl_enable,
    input  logic                      ss_n,
    input  logic                      sclk,
    input  logic [31:0]               spi_data_out,
    output logic                      spi_enable_n,
    output logic                      spi_data_valid_n,
    output logic [31:0]               spi_data_in,
    output logic [NUM_REGS*REG_W-1:0] reg_bus,
    output logic                      wr_strobe,
    output logic [6:0]                wr_addr,
    output logic [7:0]                frame_err_cnt
);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;

    spi_edge_sync u_ss_sync (
        .clock   (clock),
        .reset   (reset),
        .din_i   (ss_n),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    spi_edge_sync u_sclk_sync (
        .clock   (clock),
        .reset   (reset),
        .din_i   (sclk),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall_unused)
    );

    state_e           state_q, state_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic [31:0]      resp_q, resp_d;
    logic [7:0]       err_q, err_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [6:0]       wr_addr_q, wr_addr_d;
    logic             enable_n_q;
    logic [REG_W-1:0] regs_q [NUM_REGS];
    logic [REG_W-1:0] regs_d [NUM_REGS];

    logic [6:0]       cmd_addr;
    logic [REG_W-1:0] rd_data;

    assign cmd_addr = spi_data_out[CMD_ADDR_HI:CMD_ADDR_LO];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 7'(i)) rd_data = regs_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        settle_d    = settle_q;
        resp_d      = resp_q;
        err_d       = err_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 6'd0;
                if (ss_fall) state_d = FRAME;
            end
            FRAME: begin
                if (sclk_rise && bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
                if (ss_rise) begin
                    state_d  = SETTLE_W;
                    settle_d = 8'(SETTLE);
                end
            end
            SETTLE_W: begin
                // A new frame starting before decode means the previous
                // frame was never consumed by spi_mod: drop it as an error.
                if (ss_fall) begin
                    err_d     = sat_inc8(err_q);
                    bit_cnt_d = 6'd0;
                    state_d   = FRAME;
                end else if (settle_q <= 8'd1) begin
                    state_d = DECODE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            DECODE: begin
                state_d = LOAD;
                if (bit_cnt_q != 6'd32) begin
                    err_d  = sat_inc8(err_q);
                    resp_d = RESP_FRAME_ERR;
                end else if (32'(cmd_addr) >= NUM_REGS) begin
                    err_d  = sat_inc8(err_q);
                    resp_d = RESP_ADDR_ERR;
                end else if (spi_data_out[CMD_W_BIT]) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (cmd_addr == 7'(i)) regs_d[i] = spi_data_out[CMD_DATA_HI:CMD_DATA_LO];
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = cmd_addr;
                    resp_d      = spi_data_out;
                end else begin
                    resp_d = {1'b0, cmd_addr, rd_data};
                end
            end
            LOAD: begin
                // Master already started the next frame: skip the load and
                // count that frame from scratch.
                if (!ss_lvl) begin
                    state_d   = FRAME;
                    bit_cnt_d = 6'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!ctrl_enable) begin
            state_d     = IDLE;
            bit_cnt_d   = 6'd0;
            resp_d      = resp_q;
            err_d       = err_q;
            wr_strobe_d = 1'b0;
            wr_addr_d   = wr_addr_q;
            regs_d      = regs_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 6'd0;
            settle_q    <= 8'd0;
            resp_q      <= 32'd0;
            err_q       <= 8'd0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            enable_n_q  <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            settle_q    <= settle_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            enable_n_q  <= ~ctrl_enable;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
        assign reg_bus[g*REG_W +: REG_W] = regs_q[g];
    end

    assign spi_enable_n     = enable_n_q;
    assign spi_data_valid_n = ~((state_q == LOAD) && ss_lvl && ctrl_enable);
    assign spi_data_in      = resp_q;
    assign wr_strobe        = wr_strobe_q;
    assign wr_addr          = wr_addr_q;
    assign frame_err_cnt    = err_q;

endmodule
